// File: rtl/alu_sequencer_if.sv
// Command, ALU, response and direct-load bundle for alu_sequencer.
// The slave modport is the sequencer side; the master modport is the environment side.
interface alu_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_rd;
    logic [2:0]  cmd_rs1;
    logic [2:0]  cmd_rs2;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_opcode;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_neg;
    logic        alu_overflow;
    logic        alu_carry;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_flags;
    logic        rsp_err;

    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [31:0] ld_data;

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
        output cmd_ready,
        output alu_a, alu_b, alu_opcode,
        input  alu_result, alu_zero, alu_neg, alu_overflow, alu_carry,
        output rsp_valid, rsp_data, rsp_flags, rsp_err,
        input  rsp_ready,
        input  ld_en, ld_addr, ld_data
    );

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
        input  cmd_ready,
        input  alu_a, alu_b, alu_opcode,
        output alu_result, alu_zero, alu_neg, alu_overflow, alu_carry,
        input  rsp_valid, rsp_data, rsp_flags, rsp_err,
        output rsp_ready,
        output ld_en, ld_addr, ld_data
    );
endinterface

// File: rtl/alu_sequencer.sv
// Single-command sequencer around an external combinational ALU with an 8x32 register file.
// Optional feature macro ALU_SEQ_STICKY_FLAGS_EN adds sticky_clr / sticky_flags accumulation.
module alu_sequencer (
    input  logic             clk,
    input  logic             rst_n,
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    input  logic             sticky_clr,
    output logic [3:0]       sticky_flags,
`endif
    alu_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [7:0][31:0] r_rf;
    logic [2:0]       r_op;
    logic [2:0]       r_rd;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_rsp_data;
    logic [3:0]       r_rsp_flags;
    logic             r_rsp_err;

    logic             w_accept;
    logic             w_exec;
    logic             w_legal;
    logic [3:0]       w_flags;

    assign w_accept = bus.cmd_valid && (r_state == S_IDLE);
    assign w_exec   = (r_state == S_EXEC);
    assign w_legal  = (r_op <= 3'd4);
    assign w_flags  = {bus.alu_zero, bus.alu_neg, bus.alu_overflow, bus.alu_carry};

    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_flags = r_rsp_flags;
    assign bus.rsp_err   = r_rsp_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        bus.cmd_ready  = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.alu_a      = '0;
        bus.alu_b      = '0;
        bus.alu_opcode = '0;
        case (r_state)
            S_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) w_next = S_EXEC;
            end
            S_EXEC: begin
                bus.alu_a      = r_a;
                bus.alu_b      = r_b;
                bus.alu_opcode = r_op;
                w_next         = S_RESP;
            end
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operands are captured from the pre-edge register contents, so a same-cycle
    // load to rs1/rs2 is not seen by this command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= '0;
            r_rd        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rsp_data  <= '0;
            r_rsp_flags <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op <= bus.cmd_op;
                r_rd <= bus.cmd_rd;
                r_a  <= r_rf[bus.cmd_rs1];
                r_b  <= r_rf[bus.cmd_rs2];
            end
            if (w_exec) begin
                r_rsp_data  <= w_legal ? bus.alu_result : 32'h0;
                r_rsp_flags <= w_legal ? w_flags : 4'h0;
                r_rsp_err   <= !w_legal;
            end
        end
    end

    // r0 is never written; writeback is applied after the load so it wins a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf <= '0;
        end else begin
            if (bus.ld_en && (bus.ld_addr != 3'd0))
                r_rf[bus.ld_addr] <= bus.ld_data;
            if (w_exec && w_legal && (r_rd != 3'd0))
                r_rf[r_rd] <= bus.alu_result;
        end
    end

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    logic [3:0] r_sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_sticky <= '0;
        else if (sticky_clr)       r_sticky <= '0;
        else if (w_exec && w_legal) r_sticky <= r_sticky | w_flags;
    end

    assign sticky_flags = r_sticky;
`endif
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed scoreboard bench for alu_sequencer with a behavioural ALU model on the bus.
module tb_alu_sequencer;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  flags;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    alu_sequencer_if bus();

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    logic       sticky_clr;
    logic [3:0] sticky_flags;
    alu_sequencer dut (.clk(clk), .rst_n(rst_n), .sticky_clr(sticky_clr),
                       .sticky_flags(sticky_flags), .bus(bus));
`else
    alu_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU: carry on sub means "no borrow".
    logic [32:0] m_sum;
    logic [32:0] m_dif;
    logic [31:0] m_res;
    logic        m_v;
    logic        m_c;
    always_comb begin
        m_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        m_dif = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        m_res = '0;
        m_v   = 1'b0;
        m_c   = 1'b0;
        case (bus.alu_opcode)
            3'd0: begin
                m_res = m_sum[31:0];
                m_c   = m_sum[32];
                m_v   = (bus.alu_a[31] == bus.alu_b[31]) && (m_res[31] != bus.alu_a[31]);
            end
            3'd1: begin
                m_res = m_dif[31:0];
                m_c   = ~m_dif[32];
                m_v   = (bus.alu_a[31] != bus.alu_b[31]) && (m_res[31] != bus.alu_a[31]);
            end
            3'd2: m_res = bus.alu_a & bus.alu_b;
            3'd3: m_res = bus.alu_a | bus.alu_b;
            3'd4: m_res = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
            default: m_res = '0;
        endcase
        bus.alu_result   = m_res;
        bus.alu_zero     = (m_res == 32'd0);
        bus.alu_neg      = m_res[31];
        bus.alu_overflow = m_v;
        bus.alu_carry    = m_c;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ld(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.ld_en = 1'b1; bus.ld_addr = a; bus.ld_data = d;
        @(posedge clk);
        #1 bus.ld_en = 1'b0;
    endtask

    // ldph: 0 none, 1 load during the accept cycle, 2 load during EXEC.
    task automatic send(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic [31:0] ea, input logic [31:0] eb,
                        input logic [31:0] ed, input logic [3:0] ef, input logic ee,
                        input int stall, input int ldph, input logic [2:0] la,
                        input logic [31:0] ldd);
        exp_t e;
        exp_t got;
        int   cyc;
        e.data = ed; e.flags = ef; e.err = ee;
        exp_q.push_back(e);
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_rd = rd;
        bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2;
        if (ldph == 1) begin bus.ld_en = 1'b1; bus.ld_addr = la; bus.ld_data = ldd; end
        cyc = 0;
        while (!bus.cmd_ready && cyc < 20) begin @(negedge clk); cyc++; end
        chk("accept_ready", {31'd0, bus.cmd_ready}, 32'd1);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0; bus.ld_en = 1'b0;
        @(negedge clk);
        if (ldph == 2) begin bus.ld_en = 1'b1; bus.ld_addr = la; bus.ld_data = ldd; end
        chk("exec_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        chk("exec_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("exec_alu_a", bus.alu_a, ea);
        chk("exec_alu_b", bus.alu_b, eb);
        chk("exec_alu_op", {29'd0, bus.alu_opcode}, {29'd0, op});
        @(posedge clk);
        #1 bus.ld_en = 1'b0;
        @(negedge clk);
        chk("rsp_latency", {31'd0, bus.rsp_valid}, 32'd1);
        if (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            chk("rsp_data", bus.rsp_data, got.data);
            chk("rsp_flags", {28'd0, bus.rsp_flags}, {28'd0, got.flags});
            chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, got.err});
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("stall_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
            chk("stall_data", bus.rsp_data, ed);
            chk("stall_flags", {28'd0, bus.rsp_flags}, {28'd0, ef});
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("idle_return", {31'd0, bus.cmd_ready}, 32'd1);
        chk("idle_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_rd = '0; bus.cmd_rs1 = '0; bus.cmd_rs2 = '0;
        bus.rsp_ready = 1'b0; bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
        sticky_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_rsp_flags", {28'd0, bus.rsp_flags}, 32'd0);
        chk("rst_alu_a", bus.alu_a, 32'd0);
        rst_n = 1'b1;

        ld(3'd1, 32'd5); ld(3'd2, 32'd3);
        send(3'd0, 3'd3, 3'd1, 3'd2, 32'd5, 32'd3, 32'd8, 4'b0000, 1'b0, 0, 0, 3'd0, 32'd0);
        send(3'd0, 3'd6, 3'd3, 3'd0, 32'd8, 32'd0, 32'd8, 4'b0000, 1'b0, 0, 0, 3'd0, 32'd0);

        ld(3'd1, 32'd3); ld(3'd2, 32'd5);
        send(3'd1, 3'd4, 3'd1, 3'd2, 32'd3, 32'd5, 32'hFFFF_FFFE, 4'b0100, 1'b0, 0, 0, 3'd0, 32'd0);
        ld(3'd1, 32'd5);
        send(3'd1, 3'd4, 3'd1, 3'd2, 32'd5, 32'd5, 32'd0, 4'b1001, 1'b0, 0, 0, 3'd0, 32'd0);

        ld(3'd1, 32'h7FFF_FFFF); ld(3'd2, 32'd1);
        send(3'd0, 3'd3, 3'd1, 3'd2, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b0110, 1'b0, 0, 0, 3'd0, 32'd0);

        ld(3'd5, 32'hA5);
        send(3'd7, 3'd5, 3'd1, 3'd2, 32'h7FFF_FFFF, 32'd1, 32'd0, 4'b0000, 1'b1, 0, 0, 3'd0, 32'd0);
        send(3'd0, 3'd6, 3'd5, 3'd0, 32'hA5, 32'd0, 32'hA5, 4'b0000, 1'b0, 0, 0, 3'd0, 32'd0);

        send(3'd0, 3'd0, 3'd1, 3'd2, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b0110, 1'b0, 0, 0, 3'd0, 32'd0);
        send(3'd0, 3'd7, 3'd0, 3'd0, 32'd0, 32'd0, 32'd0, 4'b1000, 1'b0, 0, 0, 3'd0, 32'd0);

        ld(3'd1, 32'hF0F0_00FF); ld(3'd2, 32'h0FF0_0F0F);
        send(3'd2, 3'd6, 3'd1, 3'd2, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 4'b0000, 1'b0, 0, 0, 3'd0, 32'd0);
        send(3'd3, 3'd6, 3'd1, 3'd2, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 4'b0100, 1'b0, 4, 0, 3'd0, 32'd0);
        send(3'd4, 3'd6, 3'd1, 3'd2, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd1, 4'b0000, 1'b0, 0, 0, 3'd0, 32'd0);

        // Same-cycle load on accept is invisible; writeback beats a colliding load.
        ld(3'd1, 32'd10); ld(3'd2, 32'd20);
        send(3'd0, 3'd3, 3'd1, 3'd2, 32'd10, 32'd20, 32'd30, 4'b0000, 1'b0, 0, 1, 3'd1, 32'd100);
        send(3'd0, 3'd6, 3'd1, 3'd3, 32'd100, 32'd30, 32'd130, 4'b0000, 1'b0, 0, 0, 3'd0, 32'd0);
        send(3'd0, 3'd4, 3'd1, 3'd2, 32'd100, 32'd20, 32'd120, 4'b0000, 1'b0, 0, 2, 3'd4, 32'hDEAD);
        send(3'd0, 3'd6, 3'd4, 3'd0, 32'd120, 32'd0, 32'd120, 4'b0000, 1'b0, 0, 0, 3'd0, 32'd0);

        // Abort during EXEC.
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'd0; bus.cmd_rd = 3'd3; bus.cmd_rs1 = 3'd1; bus.cmd_rs2 = 3'd2;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("abort_in_exec", bus.alu_a, 32'd100);
        rst_n = 1'b0;
        #1;
        chk("abort_alu_a", bus.alu_a, 32'd0);
        chk("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("abort_rsp_data", bus.rsp_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
            chk("abort_ready", {31'd0, bus.cmd_ready}, 32'd1);
        end
        bus.rsp_ready = 1'b0;
        send(3'd0, 3'd6, 3'd3, 3'd1, 32'd0, 32'd0, 32'd0, 4'b1000, 1'b0, 0, 0, 3'd0, 32'd0);

`ifdef ALU_SEQ_STICKY_FLAGS_EN
        ld(3'd1, 32'h7FFF_FFFF); ld(3'd2, 32'd1); ld(3'd3, 32'd1);
        @(negedge clk); sticky_clr = 1'b1; @(posedge clk); #1 sticky_clr = 1'b0;
        send(3'd0, 3'd4, 3'd1, 3'd2, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b0110, 1'b0, 0, 0, 3'd0, 32'd0);
        send(3'd0, 3'd4, 3'd2, 3'd3, 32'd1, 32'd1, 32'd2, 4'b0000, 1'b0, 0, 0, 3'd0, 32'd0);
        chk("sticky_acc", {28'd0, sticky_flags}, {28'd0, 4'b0110});
        @(negedge clk); sticky_clr = 1'b1; @(posedge clk); #1 sticky_clr = 1'b0;
        @(negedge clk);
        chk("sticky_clr", {28'd0, sticky_flags}, 32'd0);
`endif

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have ports cmd_valid (in, 1), cmd_ready (out, 1), cmd_op (in, 3), cmd_rd / cmd_rs1 / cmd_rs2 (in, 3 each): upstream command channel.
REQ-004 SHALL have ports alu_a, alu_b (out, 32) and alu_opcode (out, 3): operands and opcode driven to the team's combinational ALU.
REQ-005 SHALL have ports alu_result (in, 32) and alu_zero, alu_neg, alu_overflow, alu_carry (in, 1 each): returned from the ALU in the same cycle.
REQ-006 SHALL have ports rsp_valid (out, 1), rsp_ready (in, 1), rsp_data (out, 32), rsp_flags (out, 4, {Z,N,V,C}) and rsp_err (out, 1): response channel.
REQ-007 SHALL have ports ld_en (in, 1), ld_addr (in, 3) and ld_data (in, 32): direct register-file load port.

Function
REQ-008 SHALL hold an 8x32 register file; r0 reads as 0 and ignores all writes.
REQ-009 SHALL run FSM IDLE -> EXEC -> RESP -> IDLE; cmd_ready=1 only in IDLE.
REQ-010 SHALL accept a command on cmd_valid&cmd_ready, latch op/rd and the rs1/rs2 contents (pre-write values if ld_en targets them that cycle), then enter EXEC.
REQ-011 In EXEC SHALL drive alu_a=rs1 value, alu_b=rs2 value, alu_opcode=latched op; otherwise drive all three to 0.
REQ-012 Legal ops: 000 add, 001 sub, 010 and, 011 or, 100 set-less-than; 101-111 illegal.
REQ-013 At end of EXEC for a legal op SHALL capture alu_result and flags into rsp_data/rsp_flags, write alu_result to rd, and enter RESP.
REQ-014 For an illegal op SHALL set rsp_err=1, rsp_data=0, rsp_flags=0, skip the writeback, and enter RESP.
REQ-015 SHALL assert rsp_valid throughout RESP, keep rsp_* stable until rsp_valid&rsp_ready, then return to IDLE.
REQ-016 Latency: accept in cycle N, writeback at end of N+1, rsp_valid first high in N+2; 3-cycle minimum occupancy per command.
REQ-017 SHALL let ld_en write in any state; on a same-cycle, same-address collision with writeback, the writeback wins.
REQ-018 A command reading rd of the previous command SHALL receive the written-back value (no hazard, as writeback precedes the next acceptance).

Reset
REQ-019 While rst_n=0 SHALL force FSM=IDLE, all registers r1-r7=0, rsp_valid=0, rsp_data=0, rsp_flags=0, rsp_err=0 and alu_* outputs=0.
REQ-020 Reset mid-operation SHALL abort the command with no writeback and no response; cmd_ready=1 on the first edge after release.

Configuration
REQ-021 With macro ALU_SEQ_STICKY_FLAGS_EN defined, SHALL add input sticky_clr (1) and output sticky_flags (4), OR-accumulating rsp_flags of each legal completed op; sticky_clr clears it, and on a same-cycle accumulate the clear wins; reset value 0.
REQ-022 Without ALU_SEQ_STICKY_FLAGS_EN, these ports and this logic SHALL be absent and behaviour otherwise identical.

Verification
REQ-023 ld r1=5, r2=3; cmd add rd=3 -> rsp_data=8, flags=0000, r3=8, rsp_valid 2 cycles after accept.
REQ-024 r1=3, r2=5; cmd sub rd=4 -> rsp_data=0xFFFFFFFE, N=1, C=0; r1=5, r2=5 sub -> Z=1, C=1.
REQ-025 r1=0x7FFFFFFF, r2=1; add -> rsp_data=0x80000000, V=1, N=1.
REQ-026 cmd op=111 rd=5 -> rsp_err=1, rsp_data=0, r5 unchanged; cmd rd=0 add -> r0 still reads 0.
REQ-027 Hold rsp_ready=0 for 4 cycles -> rsp_* stable, cmd_ready=0; assert rst_n=0 during EXEC -> no writeback, rsp_valid=0.
REQ-028 With ALU_SEQ_STICKY_FLAGS_EN: overflow add, then 1+1 add -> sticky_flags={0,1,1,0}; pulse sticky_clr -> 0000.
